// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - two-requester round-robin AXI read arbiter (i_cache / d_cache)
module axi_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_arvalid,
  output logic [1:0]            req_arready,
  input  logic [2*ADDR_W-1:0]   req_araddr,
  input  logic [15:0]           req_arlen,
  output logic [1:0]            req_rvalid,
  input  logic [1:0]            req_rready,
  output logic [DATA_W-1:0]     req_rdata,
  output logic                  req_rlast,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [3:0]            m_axi_arid,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic                  m_axi_rlast,
  output logic                  grant,
  output logic                  busy,
  output logic                  len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                prio_q, prio_d;      // requester that wins the next contention
  logic                len_err_q, len_err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [8:0]          cnt_q, cnt_d;        // beats already accepted in this burst
  logic                pick;
  logic                beat;

  // Round-robin choice: contention goes to prio_q, a lone requester always wins.
  always_comb begin
    if (req_arvalid == 2'b11) pick = prio_q;
    else                      pick = req_arvalid[1];
  end

  // State register and latched request; async reset returns everything to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
      len_err_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
      len_err_q <= len_err_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic and channel routing; R channel is only connected in DATA.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    prio_d        = prio_q;
    len_err_d     = len_err_q;
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    req_arready   = 2'b00;
    req_rvalid    = 2'b00;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    beat          = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_arvalid) begin
          req_arready[pick] = 1'b1;
          grant_d           = pick;
          prio_d            = ~pick;
          addr_d            = pick ? req_araddr[ADDR_W +: ADDR_W] : req_araddr[0 +: ADDR_W];
          len_d             = pick ? req_arlen[8 +: 8] : req_arlen[0 +: 8];
          state_d           = ADDR;
        end
      end
      ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        req_rvalid[grant_q] = m_axi_rvalid;
        m_axi_rready        = req_rready[grant_q];
        beat                = m_axi_rvalid & req_rready[grant_q];
        if (beat) begin
          cnt_d = cnt_q + 9'd1;
          if (m_axi_rlast) begin
            // A correct burst of len+1 beats has seen exactly len beats before rlast.
            if (cnt_q != {1'b0, len_q}) len_err_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axi_araddr = addr_q;
  assign m_axi_arlen  = len_q;
  assign m_axi_arid   = {3'b000, grant_q};
  assign req_rdata    = m_axi_rdata;
  assign req_rlast    = m_axi_rlast;
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - self-checking bench for axi_read_arbiter
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_arvalid;
  logic [1:0]  req_arready;
  logic [63:0] req_araddr;
  logic [15:0] req_arlen;
  logic [1:0]  req_rvalid;
  logic [1:0]  req_rready;
  logic [31:0] req_rdata;
  logic        req_rlast;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [3:0]  m_axi_arid;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic        m_axi_rlast;
  logic        grant;
  logic        busy;
  logic        len_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] a0, a1;
    logic [7:0]  l0, l1;
    int          stall;
    int          nbeats;
    bit          tog;
    logic        g;
    logic        err;
  } vec_t;

  typedef struct {
    logic        g;
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t sb[$];
  vec_t  tbl[9];

  axi_read_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_arvalid(req_arvalid), .req_arready(req_arready),
    .req_araddr(req_araddr), .req_arlen(req_arlen),
    .req_rvalid(req_rvalid), .req_rready(req_rready),
    .req_rdata(req_rdata), .req_rlast(req_rlast),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " m_axi_arvalid"}, 64'(m_axi_arvalid), 64'd0);
    chk({tag, " m_axi_rready"},  64'(m_axi_rready),  64'd0);
    chk({tag, " req_arready"},   64'(req_arready),   64'd0);
    chk({tag, " req_rvalid"},    64'(req_rvalid),    64'd0);
    chk({tag, " busy"},          64'(busy),          64'd0);
    chk({tag, " grant"},         64'(grant),         64'd0);
    chk({tag, " len_err"},       64'(len_err),       64'd0);
  endtask

  // Runs one complete burst; entered and left at a falling clock edge.
  task automatic run_burst(input vec_t v);
    logic [31:0] ea;
    logic [7:0]  el;
    logic [1:0]  onehot;
    logic [31:0] d;
    beat_t       e;
    int          b;
    int          cyc;
    bit          fresh;
    ea     = v.g ? v.a1 : v.a0;
    el     = v.g ? v.l1 : v.l0;
    onehot = v.g ? 2'b10 : 2'b01;
    d      = '0;
    // request phase
    req_arvalid = v.valid;
    req_araddr  = {v.a1, v.a0};
    req_arlen   = {v.l1, v.l0};
    #1;
    chk("accept arready", 64'(req_arready), 64'(onehot));
    chk("accept busy", 64'(busy), 64'd0);
    @(negedge clk);
    req_arvalid  = 2'b00;
    // stray R beats while in ADDR must not be consumed
    m_axi_rvalid = 1'b1;
    m_axi_rlast  = 1'b1;
    req_rready   = 2'b11;
    for (int i = 0; i <= v.stall; i++) begin
      m_axi_arready = (i == v.stall);
      #1;
      chk("addr arvalid", 64'(m_axi_arvalid), 64'd1);
      chk("addr araddr", 64'(m_axi_araddr), 64'(ea));
      chk("addr arlen", 64'(m_axi_arlen), 64'(el));
      chk("addr arid", 64'(m_axi_arid), 64'(v.g));
      chk("addr grant", 64'(grant), 64'(v.g));
      chk("addr busy", 64'(busy), 64'd1);
      chk("addr rready", 64'(m_axi_rready), 64'd0);
      chk("addr rvalid", 64'(req_rvalid), 64'd0);
      chk("addr arready", 64'(req_arready), 64'd0);
      @(negedge clk);
    end
    m_axi_arready = 1'b0;
    // data phase
    b     = 0;
    cyc   = 0;
    fresh = 1'b1;
    while (b < v.nbeats && cyc < 200) begin
      if (fresh) begin
        d     = $urandom;
        e.g   = v.g;
        e.d   = d;
        e.l   = (b == v.nbeats - 1);
        sb.push_back(e);
        fresh = 1'b0;
      end
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = d;
      m_axi_rlast  = (b == v.nbeats - 1);
      req_rready   = v.tog ? {2{cyc[0]}} : 2'b11;
      req_arvalid  = 2'b11;
      #1;
      chk("data rready route", 64'(m_axi_rready), 64'(req_rready[v.g]));
      chk("data rvalid route", 64'(req_rvalid), 64'(onehot));
      chk("data arready held", 64'(req_arready), 64'd0);
      if (req_rvalid[v.g] && req_rready[v.g]) begin
        if (sb.size() == 0) begin
          chk("scoreboard empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("data rdata", 64'(req_rdata), 64'(e.d));
          chk("data rlast", 64'(req_rlast), 64'(e.l));
        end
        b++;
        fresh = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    if (b < v.nbeats) chk("data beat budget", 64'(b), 64'(v.nbeats));
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    req_arvalid  = 2'b00;
    req_rready   = 2'b00;
    #1;
    chk("end busy", 64'(busy), 64'd0);
    chk("end len_err", 64'(len_err), 64'(v.err));
    chk("end rvalid", 64'(req_rvalid), 64'd0);
    chk("end arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("end scoreboard", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    //            valid  a0            a1            l0    l1    stall nb tog g     err
    tbl[0] = '{2'b11, 32'h0000_1000, 32'h0000_8000, 8'd3, 8'd2, 0, 4, 0, 1'b0, 1'b0};
    tbl[1] = '{2'b11, 32'h0000_2000, 32'h0000_3000, 8'd1, 8'd2, 0, 3, 0, 1'b1, 1'b0};
    tbl[2] = '{2'b11, 32'h0000_2000, 32'h0000_3000, 8'd1, 8'd2, 0, 2, 0, 1'b0, 1'b0};
    tbl[3] = '{2'b01, 32'h0000_1000, 32'h0000_0000, 8'd3, 8'd0, 0, 4, 0, 1'b0, 1'b0};
    tbl[4] = '{2'b11, 32'h0000_a000, 32'h0000_b000, 8'd1, 8'd2, 5, 3, 1, 1'b1, 1'b0};
    tbl[5] = '{2'b10, 32'h0000_0000, 32'h0000_c000, 8'd0, 8'd0, 0, 1, 0, 1'b1, 1'b0};
    tbl[6] = '{2'b01, 32'h0000_4000, 32'h0000_0000, 8'd3, 8'd0, 0, 2, 0, 1'b0, 1'b1};
    tbl[7] = '{2'b11, 32'h0000_5000, 32'h0000_d000, 8'd1, 8'd0, 0, 1, 0, 1'b1, 1'b1};
    tbl[8] = '{2'b10, 32'h0000_0000, 32'h0000_7000, 8'd0, 8'd0, 0, 1, 0, 1'b1, 1'b0};

    rst = 1'b1;
    req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_burst(tbl[i]);

    // mid-burst reset: d_cache burst of 4, reset during beat 2
    req_arvalid = 2'b10;
    req_araddr  = {32'h0000_6000, 32'h0};
    req_arlen   = {8'd3, 8'd0};
    #1;
    chk("mrst accept", 64'(req_arready), 64'b10);
    @(negedge clk);
    req_arvalid   = 2'b00;
    m_axi_arready = 1'b1;
    #1;
    chk("mrst arvalid", 64'(m_axi_arvalid), 64'd1);
    @(negedge clk);
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b1;
    m_axi_rdata   = 32'h1111_0001;
    req_rready    = 2'b11;
    #1;
    chk("mrst beat1 rvalid", 64'(req_rvalid), 64'b10);
    @(negedge clk);
    m_axi_rdata = 32'h1111_0002;
    #1;
    chk("mrst beat2 rvalid", 64'(req_rvalid), 64'b10);
    chk("mrst len_err before", 64'(len_err), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid-burst reset");
    @(negedge clk);
    #1;
    check_reset_outputs("held reset");
    m_axi_rvalid = 1'b0;
    req_rready   = 2'b00;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    v = tbl[8];
    run_burst(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
